rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Owns the register-file write port. In normal operation it passes the writeback-stage result (register data mux output, destination, regwrite) straight to the register file.
- When the debug unit requests the port, it stalls the CPU, waits for the pipeline to drain, grants the port to the debug unit, then returns control to the pipeline.
- Sits between the WB stage / debug unit and the register file write port.

Parameters:
- NBITS, 32, data width.
- RBITS, 5, register address width.
- DRAIN_MAX, 16, maximum cycles spent in DRAIN before forcing the grant.
- CBITS, 16, width of the write counters (optional feature only).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_regwrite  in  1  WB-stage register write enable.
- i_wb_addr  in  RBITS  WB destination register.
- i_wb_data  in  NBITS  WB data (register data mux output).
- i_pipe_empty  in  1  high when no instruction is in flight past IF.
- i_dbg_req  in  1  debug requests the port; held high for the whole session.
- i_dbg_we  in  1  debug write strobe, valid only while o_dbg_gnt=1.
- i_dbg_addr  in  RBITS  debug destination register.
- i_dbg_data  in  NBITS  debug write data.
- o_rf_we  out  1  register file write enable.
- o_rf_addr  out  RBITS  register file write address.
- o_rf_data  out  NBITS  register file write data.
- o_cpu_stall  out  1  freezes PC/IF.
- o_dbg_gnt  out  1  debug owns the port.
- o_dbg_ack  out  1  one-cycle pulse, one cycle after an accepted debug write.
- o_drain_err  out  1  sticky: drain timed out.

Behaviour:
- FSM states: RUN, DRAIN, GRANT, RELEASE. The state register and o_dbg_ack, o_drain_err and the drain counter are registered. o_rf_* and o_cpu_stall / o_dbg_gnt are decoded combinationally from the state register.
- Reset: state RUN, drain counter 0, o_dbg_ack 0, o_drain_err 0. With state RUN: o_cpu_stall 0, o_dbg_gnt 0.
- RUN:
  - o_rf_* = WB inputs, same cycle (zero latency).
  - On i_dbg_req=1 -> DRAIN. A WB write in that same cycle is still performed.
- DRAIN:
  - o_cpu_stall=1; WB writes are still passed through.
  - Counter increments each cycle.
  - Exit to GRANT when i_pipe_empty=1 and i_wb_regwrite=0.
  - Also exit to GRANT when the counter reaches DRAIN_MAX-1; this sets o_drain_err.
  - If i_dbg_req drops while in DRAIN -> RELEASE.
  - Counter clears on leaving DRAIN.
- GRANT:
  - o_cpu_stall=1, o_dbg_gnt=1.
  - o_rf_we = i_dbg_we; o_rf_addr / o_rf_data = debug inputs, same cycle.
  - i_wb_regwrite is ignored.
  - Accepted write -> o_dbg_ack=1 on the next cycle. Back-to-back writes give back-to-back acks.
  - i_dbg_req=0 -> RELEASE. A write strobe in that same cycle is ignored (no write, no ack).
- RELEASE: one cycle with o_cpu_stall=1, o_dbg_gnt=0, o_rf_we=0, then RUN.
- Register 0: any write (either source) to address 0 forces o_rf_we=0. No debug ack is issued for it.
- Writes when not granted: i_dbg_we is ignored outside GRANT.
- Default values: o_rf_we=0 whenever no source is selected. Addr/data then follow the WB inputs.
- Reset mid-session: returns to RUN immediately and the stall releases on the next cycle. o_drain_err clears only on reset.

Optional Feature:
- Macro RF_ARB_CNT_EN.
- When defined, adds ports o_wb_wr_cnt and o_dbg_wr_cnt (CBITS each, out). Each counts performed writes per source.
  - Writes to register 0 are not counted.
  - Counters wrap modulo 2^CBITS and reset to 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN=2'b00, DRAIN=2'b01, GRANT=2'b10, RELEASE=2'b11.
  - NBITS/RBITS defaults.
  - The REG_ZERO constant.
- One sub-module, rf_arb_fsm: state, drain counter and error flag, with stall/grant outputs.
- Datapath muxing stays in the top.

Test Plan:
- RUN passthrough: WB writes r5=0x1234_5678 -> o_rf_we=1, addr 5, data 0x12345678 the same cycle; o_cpu_stall=0.
- Session:
  - Stimulus: dbg_req=1 while a WB write is in flight; i_pipe_empty rises 3 cycles later.
  - Required: stall asserts the next cycle; the WB write completes; o_dbg_gnt is high 4 cycles after the request.
  - Then debug writes r1=0xA, r2=0xB back-to-back -> two rf writes and acks on cycles +1 and +2.
- Release: drop dbg_req in GRANT -> one RELEASE cycle (stall=1, gnt=0), then RUN with stall=0.
- Timeout: dbg_req=1 with i_pipe_empty held 0 -> GRANT after DRAIN_MAX cycles; o_drain_err=1 and stays high until i_reset.
- r0 guard:
  - WB write to r0 and debug write to r0 -> o_rf_we=0, no ack.
  - With RF_ARB_CNT_EN, neither counter increments.
- Reset mid-GRANT: assert i_reset -> next cycle state RUN, stall=0, gnt=0, ack=0, counters 0.

Source files
------------

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encoding, default widths and the hard-wired zero register.
package rf_wr_arbiter_pkg;

    localparam int NBITS_DEF = 32;
    localparam int RBITS_DEF = 5;
    localparam int REG_ZERO  = 0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_GRANT   = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_e;

endpackage

// File: rtl/rf_wr_arbiter_fsm.sv
// Session controller for the register-file write-port arbiter.
// Holds the ownership state, the drain watchdog counter and the sticky
// drain-timeout flag; stall and grant are decoded from the state register.
module rf_arb_fsm
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DRAIN_MAX = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_dbg_req,
    input  logic       i_pipe_empty,
    input  logic       i_wb_regwrite,
    output arb_state_e o_state,
    output logic       o_cpu_stall,
    output logic       o_dbg_gnt,
    output logic       o_drain_err
);

    // Counter only has to reach DRAIN_MAX-1.
    localparam int            CW       = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          err_r;
    logic          err_nxt_s;

    // Next-state logic: session sequencing, drain watchdog and timeout flag.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = {CW{1'b0}};
        err_nxt_s   = err_r;
        case (state_r)
            ST_RUN: begin
                if (i_dbg_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!i_dbg_req) begin
                    // Debug gave up before being granted: hand back the pipe.
                    state_nxt_s = ST_RELEASE;
                end else if (i_pipe_empty && !i_wb_regwrite) begin
                    state_nxt_s = ST_GRANT;
                end else if (cnt_r == CNT_LAST) begin
                    // Pipe never drained: grant anyway and remember it.
                    state_nxt_s = ST_GRANT;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            ST_GRANT: begin
                if (!i_dbg_req) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State, drain counter and sticky error registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_RUN;
            cnt_r   <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Stall/grant decode: the CPU is frozen in every state except RUN.
    always_comb begin
        o_cpu_stall = 1'b0;
        o_dbg_gnt   = 1'b0;
        case (state_r)
            ST_RUN: begin
                o_cpu_stall = 1'b0;
                o_dbg_gnt   = 1'b0;
            end
            ST_DRAIN: begin
                o_cpu_stall = 1'b1;
                o_dbg_gnt   = 1'b0;
            end
            ST_GRANT: begin
                o_cpu_stall = 1'b1;
                o_dbg_gnt   = 1'b1;
            end
            ST_RELEASE: begin
                o_cpu_stall = 1'b1;
                o_dbg_gnt   = 1'b0;
            end
            default: begin
                o_cpu_stall = 1'b0;
                o_dbg_gnt   = 1'b0;
            end
        endcase
    end

    assign o_state     = state_r;
    assign o_drain_err = err_r;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter.
// Normally forwards the writeback-stage write straight to the register file;
// on a debug request it stalls the CPU, drains the pipe, lends the port to
// the debug unit and then hands it back.
// Optional build macro RF_ARB_CNT_EN adds per-source performed-write counters
// (o_wb_wr_cnt, o_dbg_wr_cnt); register 0 writes are never performed.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int NBITS     = NBITS_DEF,
    parameter int RBITS     = RBITS_DEF,
    parameter int DRAIN_MAX = 16,
    parameter int CBITS     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_regwrite,
    input  logic [RBITS-1:0] i_wb_addr,
    input  logic [NBITS-1:0] i_wb_data,
    input  logic             i_pipe_empty,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [RBITS-1:0] i_dbg_addr,
    input  logic [NBITS-1:0] i_dbg_data,
    output logic             o_rf_we,
    output logic [RBITS-1:0] o_rf_addr,
    output logic [NBITS-1:0] o_rf_data,
    output logic             o_cpu_stall,
    output logic             o_dbg_gnt,
    output logic             o_dbg_ack,
`ifdef RF_ARB_CNT_EN
    output logic [CBITS-1:0] o_wb_wr_cnt,
    output logic [CBITS-1:0] o_dbg_wr_cnt,
`endif
    output logic             o_drain_err
);

    localparam logic [RBITS-1:0] ZERO_ADDR = RBITS'(REG_ZERO);

    arb_state_e state_s;
    logic       wb_wr_s;
    logic       dbg_wr_s;
    logic       ack_r;

    rf_arb_fsm #(
        .DRAIN_MAX (DRAIN_MAX)
    ) u_fsm (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_dbg_req     (i_dbg_req),
        .i_pipe_empty  (i_pipe_empty),
        .i_wb_regwrite (i_wb_regwrite),
        .o_state       (state_s),
        .o_cpu_stall   (o_cpu_stall),
        .o_dbg_gnt     (o_dbg_gnt),
        .o_drain_err   (o_drain_err)
    );

    // Qualify each source's write: owner state, live strobe, and never r0.
    always_comb begin
        wb_wr_s  = 1'b0;
        dbg_wr_s = 1'b0;
        if ((state_s == ST_RUN) || (state_s == ST_DRAIN)) begin
            wb_wr_s = i_wb_regwrite && (i_wb_addr != ZERO_ADDR);
        end else begin
            wb_wr_s = 1'b0;
        end
        if (state_s == ST_GRANT) begin
            // A strobe in the cycle the request drops is discarded.
            dbg_wr_s = i_dbg_req && i_dbg_we && (i_dbg_addr != ZERO_ADDR);
        end else begin
            dbg_wr_s = 1'b0;
        end
    end

    // Write-port mux: WB path by default, debug path while granted.
    always_comb begin
        o_rf_we   = 1'b0;
        o_rf_addr = i_wb_addr;
        o_rf_data = i_wb_data;
        case (state_s)
            ST_RUN, ST_DRAIN: begin
                o_rf_we = wb_wr_s;
            end
            ST_GRANT: begin
                o_rf_we   = dbg_wr_s;
                o_rf_addr = i_dbg_addr;
                o_rf_data = i_dbg_data;
            end
            ST_RELEASE: begin
                o_rf_we = 1'b0;
            end
            default: begin
                o_rf_we = 1'b0;
            end
        endcase
    end

    // Debug acknowledge: one pulse the cycle after each performed debug write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= dbg_wr_s;
        end
    end

    assign o_dbg_ack = ack_r;

`ifdef RF_ARB_CNT_EN
    logic [CBITS-1:0] wb_cnt_r;
    logic [CBITS-1:0] dbg_cnt_r;

    // Performed-write counters per source, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_cnt_r  <= {CBITS{1'b0}};
            dbg_cnt_r <= {CBITS{1'b0}};
        end else begin
            if (wb_wr_s) begin
                wb_cnt_r <= wb_cnt_r + CBITS'(1);
            end
            if (dbg_wr_s) begin
                dbg_cnt_r <= dbg_cnt_r + CBITS'(1);
            end
        end
    end

    assign o_wb_wr_cnt  = wb_cnt_r;
    assign o_dbg_wr_cnt = dbg_cnt_r;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: per-cycle expected outputs are
// pushed to a scoreboard queue when inputs are driven and popped/compared
// at the following falling edge.
module tb_rf_wr_arbiter;

    localparam int NBITS     = 32;
    localparam int RBITS     = 5;
    localparam int DRAIN_MAX = 16;
    localparam int CBITS     = 16;

    typedef struct packed {
        logic             we;
        logic [RBITS-1:0] addr;
        logic [NBITS-1:0] data;
        logic             stall;
        logic             gnt;
        logic             ack;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             wb_regwrite;
    logic [RBITS-1:0] wb_addr;
    logic [NBITS-1:0] wb_data;
    logic             pipe_empty;
    logic             dbg_req;
    logic             dbg_we;
    logic [RBITS-1:0] dbg_addr;
    logic [NBITS-1:0] dbg_data;
    logic             rf_we;
    logic [RBITS-1:0] rf_addr;
    logic [NBITS-1:0] rf_data;
    logic             cpu_stall;
    logic             dbg_gnt;
    logic             dbg_ack;
    logic             drain_err;
`ifdef RF_ARB_CNT_EN
    logic [CBITS-1:0] wb_wr_cnt;
    logic [CBITS-1:0] dbg_wr_cnt;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    rf_wr_arbiter #(
        .NBITS     (NBITS),
        .RBITS     (RBITS),
        .DRAIN_MAX (DRAIN_MAX),
        .CBITS     (CBITS)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_wb_regwrite (wb_regwrite),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .i_pipe_empty  (pipe_empty),
        .i_dbg_req     (dbg_req),
        .i_dbg_we      (dbg_we),
        .i_dbg_addr    (dbg_addr),
        .i_dbg_data    (dbg_data),
        .o_rf_we       (rf_we),
        .o_rf_addr     (rf_addr),
        .o_rf_data     (rf_data),
        .o_cpu_stall   (cpu_stall),
        .o_dbg_gnt     (dbg_gnt),
        .o_dbg_ack     (dbg_ack),
`ifdef RF_ARB_CNT_EN
        .o_wb_wr_cnt   (wb_wr_cnt),
        .o_dbg_wr_cnt  (dbg_wr_cnt),
`endif
        .o_drain_err   (drain_err)
    );

    // Free-running clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Run-time guard so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic drv(input logic wwe, input logic [RBITS-1:0] wa, input logic [NBITS-1:0] wd,
                       input logic pe, input logic req, input logic dwe,
                       input logic [RBITS-1:0] da, input logic [NBITS-1:0] dd);
        wb_regwrite = wwe;
        wb_addr     = wa;
        wb_data     = wd;
        pipe_empty  = pe;
        dbg_req     = req;
        dbg_we      = dwe;
        dbg_addr    = da;
        dbg_data    = dd;
    endtask

    task automatic push(input logic we, input logic [RBITS-1:0] a, input logic [NBITS-1:0] d,
                        input logic st, input logic gn, input logic ak, input logic er);
        exp_t e;
        e.we    = we;
        e.addr  = a;
        e.data  = d;
        e.stall = st;
        e.gnt   = gn;
        e.ack   = ak;
        e.err   = er;
        exp_q.push_back(e);
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("rf_we",     {31'd0, rf_we},     {31'd0, e.we});
            check_eq("rf_addr",   {27'd0, rf_addr},   {27'd0, e.addr});
            check_eq("rf_data",   rf_data,            e.data);
            check_eq("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
            check_eq("dbg_gnt",   {31'd0, dbg_gnt},   {31'd0, e.gnt});
            check_eq("dbg_ack",   {31'd0, dbg_ack},   {31'd0, e.ack});
            check_eq("drain_err", {31'd0, drain_err}, {31'd0, e.err});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        drv(1'b0, 5'd7, 32'h1111_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd7, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef RF_ARB_CNT_EN
        check_eq("wb_cnt_reset",  {16'd0, wb_wr_cnt},  32'd0);
        check_eq("dbg_cnt_reset", {16'd0, dbg_wr_cnt}, 32'd0);
`endif
        rst = 1'b0;

        // RUN passthrough
        drv(1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        push(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Session: request with WB write in flight, pipe empties 3 cycles later
        drv(1'b1, 5'd3, 32'h55, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b1, 5'd3, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd4, 32'h66, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b1, 5'd4, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 5'd4, 32'h66, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd4, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 5'd4, 32'h66, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd4, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        // Granted: back-to-back debug writes, WB strobe ignored
        drv(1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 5'd1, 32'hA);
        push(1'b1, 5'd1, 32'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 5'd2, 32'hB);
        push(1'b1, 5'd2, 32'hB, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b0, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0, 5'd2, 32'hB);
        push(1'b0, 5'd2, 32'hB, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        // Debug write to r0: suppressed, no ack
        drv(1'b0, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 5'd0, 32'h77);
        push(1'b0, 5'd0, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b0, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0, 5'd0, 32'h77);
        push(1'b0, 5'd0, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        // Release with a strobe in the same cycle: ignored
        drv(1'b0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b1, 5'd6, 32'hCC);
        push(1'b0, 5'd6, 32'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd8, 32'h99, 1'b1, 1'b0, 1'b0, 5'd6, 32'hCC);
        push(1'b0, 5'd8, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        // Back in RUN; debug strobe outside grant is ignored
        drv(1'b1, 5'd8, 32'h99, 1'b1, 1'b0, 1'b1, 5'd3, 32'hEE);
        push(1'b1, 5'd8, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // WB write to r0 suppressed
        drv(1'b1, 5'd0, 32'h42, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd0, 32'h42, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef RF_ARB_CNT_EN
        check_eq("wb_cnt_session",  {16'd0, wb_wr_cnt},  32'd4);
        check_eq("dbg_cnt_session", {16'd0, dbg_wr_cnt}, 32'd2);
`endif

        // Timeout: pipe never empties
        drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < DRAIN_MAX; i++) begin
            push(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1);
        push(1'b1, 5'd5, 32'h1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1);
        push(1'b0, 5'd5, 32'h1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset mid-GRANT, with an accepted write in the reset cycle
        drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h3);
        push(1'b1, 5'd7, 32'h3, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef RF_ARB_CNT_EN
        check_eq("wb_cnt_after_reset",  {16'd0, wb_wr_cnt},  32'd0);
        check_eq("dbg_cnt_after_reset", {16'd0, dbg_wr_cnt}, 32'd0);
`endif

        // Request dropped during DRAIN goes through RELEASE
        drv(1'b0, 5'd2, 32'h21, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd2, 32'h21, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 5'd2, 32'h21, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd2, 32'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        push(1'b0, 5'd2, 32'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        push(1'b0, 5'd2, 32'h21, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
